// File: rtl/uart_receive_ram_if.sv
// Signal bundle between the UART receive queue and its host: serial input,
// pop request, popped data and queue/receiver status.
interface uart_receive_ram_if;
  logic       rx;
  logic       rd_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       empty;
  logic       full;
  logic [8:0] count;
  logic       rx_busy;
  logic       frame_error;
  logic       overflow;

  modport slave (
    input  rx, rd_en,
    output data_out, data_valid, empty, full, count, rx_busy, frame_error, overflow
  );

  modport master (
    output rx, rd_en,
    input  data_out, data_valid, empty, full, count, rx_busy, frame_error, overflow
  );
endinterface

// File: rtl/uart_receive_ram.sv
// UART 8N1 receiver feeding a 256x8 circular queue that the host drains
// one byte per rd_en cycle; single clock domain, bit timing from a divider.
module uart_receive_ram #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  uart_receive_ram_if.slave   bus
);

  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OCC_W  = 9;
  localparam int unsigned DEPTH  = 256;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  logic              fall_c;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              push_c, ferr_c;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              empty_q, full_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q, ferr_q, overflow_q, rx_busy_q;
  logic              push_ok_c, pop_ok_c;

  // Synchroniser resets low so a line held low across reset needs a fresh high->low edge.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall_c = rx_prev_q & ~rx_sync_q;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_c  = 1'b0;
    ferr_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d = START;
          cnt_d   = CNT_W'(CLKS_PER_BIT / 2 - 1);
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_sync_q) begin
            state_d = DATA;
            cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[DATA_W-1:1]};
          cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rx_sync_q) begin
            push_c = 1'b1;
          end else begin
            ferr_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push into a full queue is still taken when the same cycle pops a byte.
  assign push_ok_c = push_c & (~full_q | bus.rd_en);
  assign pop_ok_c  = bus.rd_en & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset && push_ok_c) begin
      ram[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
      overflow_q   <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      if (push_ok_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_c) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        data_out_q <= ram[rd_ptr_q];
      end
      if (push_c && !push_ok_c) begin
        overflow_q <= 1'b1;
      end
      data_valid_q <= pop_ok_c;
      count_q      <= count_d;
      empty_q      <= (count_d == '0);
      full_q       <= (count_d == OCC_W'(DEPTH));
      ferr_q       <= ferr_c;
      rx_busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.count       = count_q;
  assign bus.rx_busy     = rx_busy_q;
  assign bus.frame_error = ferr_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: doc/uart_receive_ram.md
# uart_receive_ram

Receive-side counterpart of the launch buffer: a UART 8N1 receiver that assembles serial bytes from the `rx` line and queues them in a 256×8 circular RAM. Host logic drains the queue one byte at a time. It sits between the board's RX pin and the command/display logic and runs entirely in the CLK100MHZ domain; bit timing is derived internally from a cycle divider.

## Interface
Parameters:
- CLKS_PER_BIT, 10417, CLK100MHZ cycles per bit (9600 baud). Legal range ≥ 4. The bench uses 16.

Ports:
- CLK100MHZ  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  serial input; idles high; asynchronous, so it passes through a 2-flop synchroniser before use.
- rd_en  in  1  pop request; one byte per asserted cycle.
- data_out  out  8  popped byte; registered; holds its value until the next successful pop.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- empty  out  1  queue holds 0 bytes.
- full  out  1  queue holds 256 bytes.
- count  out  9  occupancy, 0..256.
- rx_busy  out  1  receiver FSM is not in IDLE.
- frame_error  out  1  one-cycle pulse when the stop bit samples low.
- overflow  out  1  sticky; set when a completed byte is dropped because the queue is full; cleared only by reset.

## Operation
- Receiver FSM states:
  - IDLE: on a synchronised falling edge (previous 1, current 0), go to START and load the bit counter with CLKS_PER_BIT/2−1 (integer division).
  - START: when the counter expires, sample rx. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE.
  - DATA: wait CLKS_PER_BIT cycles per bit, then sample. Bits arrive LSB first into a shift register. After the 8th sample, go to STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample. If 1, issue a push. If 0, pulse frame_error and discard the byte. Either way, return to IDLE.
- Queue: 8-bit write and read pointers that wrap 255→0; count is 9 bits.
  - Push is accepted when `!full || rd_en`. Otherwise the byte is dropped and overflow is set.
  - Pop is accepted when `!empty`. An rd_en while empty is ignored: no data_valid, and data_out is unchanged.
  - Simultaneous accepted push and pop: both pointers advance and count is unchanged.
  - When full and rd_en are both high in the cycle a push is issued, the push is accepted and count stays 256.
- RAM contents are not cleared by reset; only the pointers and count are. Stale data is unreachable.
- Reset during a frame aborts it: the partial byte is discarded and the FSM returns to IDLE. A new start bit is accepted only after a fresh high→low edge.

## Timing
- Reset values: data_out = 0, data_valid = 0, empty = 1, full = 0, count = 0, rx_busy = 0, frame_error = 0, overflow = 0. Pointers = 0. FSM = IDLE.
- Synchroniser latency: 2 cycles from the rx pin to the FSM input.
- Sample points fall at the nominal mid-bit. Stop-bit sample occurs roughly 9.5×CLKS_PER_BIT + 2 cycles after the pin falls.
- Push happens on the edge following the stop-bit sample; count, empty and full update on that edge.
- Pop: rd_en sampled high on edge N gives data_out and data_valid valid after edge N, and count updates on that same edge.
- Popped data comes from a registered RAM read, so rd_en can be held high for back-to-back pops.
- frame_error is a single-cycle pulse, asserted on the edge after the stop sample.
- rx_busy is high from the IDLE→START transition until the return to IDLE.

## Test plan
- Single byte: reset, then send 0xA5 at CLKS_PER_BIT=16. Expect count=1 and empty=0. Pulse rd_en → data_out=0xA5, data_valid for 1 cycle, count=0, empty=1.
- Glitch rejection: pull rx low for 4 cycles, then high. Expect the FSM back in IDLE, count=0, and no frame_error.
- Framing error: send 0x3C with the stop bit held low. Expect frame_error to pulse once, count=0, then correct reception of a following 0x55.
- Fill and overflow: send 256 bytes 0x00..0xFF → full=1, count=256. Send 0x77 → overflow=1, count=256. Drain all 256 → values 0x00..0xFF in order, then empty=1.
- Simultaneous push and pop at count=256: hold rd_en high as the stop bit completes. Expect count=256, overflow=0, and the new byte later read out after the wrap.
- Reset mid-frame: assert reset during DATA bit 4. Expect all outputs at their reset values. Then send 0x81 → received correctly.
